// File: rtl/preamble_pkg.sv
// Shared types and training-sequence tables for the 802.11a/g legacy preamble generator.
// Samples are the standard time-domain STS/LTS values, scaled so that 1.0 = ROM_SCALE.
package preamble_pkg;

  typedef enum logic [2:0] {S_IDLE, S_SHORT, S_LONG, S_DATA, S_GAP} state_t;

  localparam int STS_LEN   = 16;
  localparam int LTS_LEN   = 64;
  localparam int LTS_GI    = 32;
  localparam int ROM_SCALE = 8192;

  localparam int STS_I [STS_LEN] = '{
     377, -1081,  -106,  1171,   754,  1171,  -106, -1081,
     377,    16,  -647,  -106,     0,  -106,  -647,    16};
  localparam int STS_Q [STS_LEN] = '{
     377,    16,  -647,  -106,     0,  -106,  -647,    16,
     377, -1081,  -106,  1171,   754,  1171,  -106, -1081};

  localparam int LTS_I [LTS_LEN] = '{
    1278,   -41,   328,   795,   172,   492,  -942,  -311,
     803,   434,     8, -1122,   197,   483,  -180,   975,
     508,   303,  -467, -1073,   672,   573,  -492,  -459,
    -287,  -999, -1040,   614,   -25,  -754,   754,    98,
   -1278,    98,   754,  -754,   -25,   614, -1040,  -999,
    -287,  -459,  -492,   573,   672, -1073,  -467,   303,
     508,   975,  -180,   483,   197, -1122,     8,   434,
     803,  -311,  -942,   492,   172,   795,   328,   -41};
  localparam int LTS_Q [LTS_LEN] = '{
       0,  -983,  -909,   680,   229,  -721,  -451,  -868,
    -213,    33,  -942,  -385,  -483,  -123,  1319,   -33,
    -508,   803,   319,   532,   754,   115,   664,  -180,
   -1237,  -139,  -172,  -606,   442,   942,   868,   803,
       0,  -803,  -868,  -942,  -442,   606,   172,   139,
    1237,   180,  -664,  -115,  -754,  -532,  -319,  -803,
     508,    33, -1319,   123,   483,   385,   942,   -33,
     213,   868,   451,   721,  -229,  -680,   909,   983};

endpackage

// File: rtl/preamble_rom.sv
// Combinational STS/LTS lookup returning {Q,I}, each component arithmetically shifted
// right by SHIFT for amplitude backoff.
module preamble_rom
  import preamble_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHIFT = 0
) (
  input  logic               i_sel_lts,
  input  logic [5:0]         i_index,
  output logic [2*WIDTH-1:0] o_sample
);

  int w_i;
  int w_q;

  always_comb begin
    if (i_sel_lts) begin
      w_i = LTS_I[i_index];
      w_q = LTS_Q[i_index];
    end else begin
      w_i = STS_I[i_index[3:0]];
      w_q = STS_Q[i_index[3:0]];
    end
    o_sample = {WIDTH'(w_q >>> SHIFT), WIDTH'(w_i >>> SHIFT)};
  end

endmodule

// File: rtl/preamble_generator.sv
// Prepends the 802.11a/g legacy preamble (STS, guard + LTS) to each payload frame.
// Optional PREAMBLE_GAP_EN macro appends GAP zero samples after every frame.
module preamble_generator
  import preamble_pkg::*;
#(
  parameter int WIDTH          = 16,
  parameter int STS_REPEAT     = 10,
  parameter int LTS_REPEAT     = 2,
  parameter int PREAMBLE_SHIFT = 0,
  parameter int GAP            = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [2*WIDTH-1:0] s_data,
  input  logic               s_last,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [2*WIDTH-1:0] m_data,
  output logic               m_last,
  output logic               busy
);

  localparam logic [7:0] STS_LAST = 8'(STS_LEN * STS_REPEAT - 1);
  localparam logic [7:0] LTS_LAST = 8'(LTS_GI + LTS_LEN * LTS_REPEAT - 1);
  localparam logic [7:0] GAP_LAST = 8'(GAP - 1);

  state_t             r_state, w_state_next;
  logic [7:0]         r_cnt, w_cnt_next;
  logic               r_m_valid, r_m_last;
  logic [2*WIDTH-1:0] r_m_data;

  logic               w_adv;
  logic               w_rom_lts;
  logic [5:0]         w_rom_idx;
  logic [2*WIDTH-1:0] w_rom_data;
  logic               w_nxt_valid, w_nxt_last;
  logic [2*WIDTH-1:0] w_nxt_data;

  assign w_adv = !r_m_valid || m_ready;

  preamble_rom #(
    .WIDTH (WIDTH),
    .SHIFT (PREAMBLE_SHIFT)
  ) u_rom (
    .i_sel_lts (w_rom_lts),
    .i_index   (w_rom_idx),
    .o_sample  (w_rom_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // STS beat 0 is loaded on the IDLE exit edge, so SHORT resumes from count 1.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    if (w_adv) begin
      case (r_state)
        S_IDLE: if (s_valid) begin
          w_state_next = S_SHORT;
          w_cnt_next   = 8'd1;
        end
        S_SHORT: if (r_cnt == STS_LAST) begin
          w_state_next = S_LONG;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + 8'd1;
        end
        S_LONG: if (r_cnt == LTS_LAST) begin
          w_state_next = S_DATA;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + 8'd1;
        end
        S_DATA: if (s_valid && s_last) begin
`ifdef PREAMBLE_GAP_EN
          w_state_next = S_GAP;
`else
          w_state_next = S_IDLE;
`endif
          w_cnt_next = '0;
        end
        S_GAP: if (r_cnt == GAP_LAST) begin
          w_state_next = S_IDLE;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + 8'd1;
        end
        default: begin
          w_state_next = S_IDLE;
          w_cnt_next   = '0;
        end
      endcase
    end
  end

  always_comb begin
    s_ready     = (r_state == S_DATA) && w_adv;
    busy        = (r_state != S_IDLE);
    w_rom_lts   = (r_state == S_LONG);
    w_rom_idx   = w_rom_lts ? (r_cnt[5:0] + 6'd32) : {2'b00, r_cnt[3:0]};
    w_nxt_valid = 1'b0;
    w_nxt_last  = 1'b0;
    w_nxt_data  = r_m_data;
    case (r_state)
      S_IDLE: if (s_valid) begin
        w_nxt_valid = 1'b1;
        w_nxt_data  = w_rom_data;
      end
      S_SHORT, S_LONG: begin
        w_nxt_valid = 1'b1;
        w_nxt_data  = w_rom_data;
      end
      S_DATA: if (s_valid) begin
        w_nxt_valid = 1'b1;
        w_nxt_last  = s_last;
        w_nxt_data  = s_data;
      end
      S_GAP: begin
        w_nxt_valid = 1'b1;
        w_nxt_data  = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_m_valid <= 1'b0;
      r_m_last  <= 1'b0;
      r_m_data  <= '0;
    end else if (w_adv) begin
      r_m_valid <= w_nxt_valid;
      r_m_last  <= w_nxt_last;
      r_m_data  <= w_nxt_data;
    end
  end

  assign m_valid = r_m_valid;
  assign m_last  = r_m_last;
  assign m_data  = r_m_data;

endmodule

// File: tb/tb_preamble_generator.sv
// Directed bench for preamble_generator: full frames, backpressure, payload underflow,
// mid-frame reset, back-to-back frames, and a PREAMBLE_SHIFT=2 instance in lockstep.
module tb_preamble_generator;

  logic        clk = 1'b0;
  logic        reset;
  logic        s_valid, s_last, m_ready;
  logic [31:0] s_data;
  logic        s_ready, m_valid, m_last, busy;
  logic [31:0] m_data;
  logic        s_ready2, m_valid2, m_last2, busy2;
  logic [31:0] m_data2;

  always #5 clk = ~clk;

  preamble_generator u_dut (
    .clk (clk), .reset (reset),
    .s_valid (s_valid), .s_ready (s_ready), .s_data (s_data), .s_last (s_last),
    .m_valid (m_valid), .m_ready (m_ready), .m_data (m_data), .m_last (m_last),
    .busy (busy)
  );

  preamble_generator #(.PREAMBLE_SHIFT(2)) u_dut_sh (
    .clk (clk), .reset (reset),
    .s_valid (s_valid), .s_ready (s_ready2), .s_data (s_data), .s_last (s_last),
    .m_valid (m_valid2), .m_ready (m_ready), .m_data (m_data2), .m_last (m_last2),
    .busy (busy2)
  );

`ifdef PREAMBLE_GAP_EN
  localparam int GAPN = 16;
`else
  localparam int GAPN = 0;
`endif
  localparam int FL = 324 + GAPN;

  // Reference training samples in thousandths (802.11a tables)
  int sts_i [16] = '{46, -132, -13, 143, 92, 143, -13, -132, 46, 2, -79, -13, 0, -13, -79, 2};
  int sts_q [16] = '{46, 2, -79, -13, 0, -13, -79, 2, 46, -132, -13, 143, 92, 143, -13, -132};
  int lts_i [64] = '{156, -5, 40, 97, 21, 60, -115, -38, 98, 53, 1, -137, 24, 59, -22, 119,
                     62, 37, -57, -131, 82, 70, -60, -56, -35, -122, -127, 75, -3, -92, 92, 12,
                     -156, 12, 92, -92, -3, 75, -127, -122, -35, -56, -60, 70, 82, -131, -57, 37,
                     62, 119, -22, 59, 24, -137, 1, 53, 98, -38, -115, 60, 21, 97, 40, -5};
  int lts_q [64] = '{0, -120, -111, 83, 28, -88, -55, -106, -26, 4, -115, -47, -59, -15, 161, -4,
                     -62, 98, 39, 65, 92, 14, 81, -22, -151, -17, -21, -74, 54, 115, 106, 98,
                     0, -98, -106, -115, -54, 74, 21, 17, 151, 22, -81, -14, -92, -65, -39, -98,
                     62, 4, -161, 15, 59, 47, 115, -4, 26, 106, 55, 88, -28, -83, 111, 120};

  int chk = 0;
  int errs = 0;

  logic [31:0] pd [0:7];
  logic        pl [0:7];
  int          np, pi;
  bit          rnd_rdy, tog;

  logic [31:0] bd [0:1023];
  logic [31:0] bd2 [0:1023];
  logic        bl [0:1023];
  logic        bl2 [0:1023];
  int          bc [0:1023];
  int          nb, pre_bubbles, data_bubbles;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int scl(input int m);
    return (m >= 0) ? (m * 8192 + 500) / 1000 : -((-m * 8192 + 500) / 1000);
  endfunction

  function automatic logic [31:0] pre_word(input int j, input int sh);
    int i, q, k;
    if (j < 160) begin
      i = scl(sts_i[j % 16]);
      q = scl(sts_q[j % 16]);
    end else begin
      k = (j - 160 + 32) % 64;
      i = scl(lts_i[k]);
      q = scl(lts_q[k]);
    end
    return {16'(q >>> sh), 16'(i >>> sh)};
  endfunction

  task automatic run(input int target, input int budget);
    bit          st_prev;
    logic [31:0] st_d;
    logic        st_l;
    int          j;
    nb = 0; pi = 0; pre_bubbles = 0; data_bubbles = 0; st_prev = 0;
    st_d = '0; st_l = 1'b0;
    for (int c = 0; c < budget && nb < target; c++) begin
      @(negedge clk);
      m_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      s_valid = (pi < np) && !(tog && c[0]);
      s_data  = (pi < np) ? pd[pi] : '0;
      s_last  = (pi < np) ? pl[pi] : 1'b0;
      #1;
      if (st_prev) begin
        check("stall_data", m_data, st_d);
        check("stall_last", {31'd0, m_last}, {31'd0, st_l});
      end
      if (!m_valid && nb > 0) begin
        j = nb % FL;
        if (j >= 320 && j <= 323) data_bubbles++;
        else pre_bubbles++;
      end
      if (m_valid && m_ready) begin
        bd[nb] = m_data; bl[nb] = m_last; bc[nb] = c;
        nb++;
      end
      if (m_valid2 && m_ready && nb > 0) begin
        bd2[nb-1] = m_data2; bl2[nb-1] = m_last2;
      end
      if (s_valid && s_ready) pi++;
      st_prev = m_valid && !m_ready;
      st_d = m_data;
      st_l = m_last;
    end
    check("beat_count", nb, target);
  endtask

  task automatic check_seq(input string tag);
    int j, f, bad, bad2;
    logic [31:0] e, e2;
    bad = 0; bad2 = 0;
    for (int k = 0; k < nb; k++) begin
      f = k / FL;
      j = k % FL;
      if (j < 320) begin
        e = pre_word(j, 0); e2 = pre_word(j, 2);
      end else if (j < 324) begin
        e = pd[f * 4 + j - 320]; e2 = e;
      end else begin
        e = '0; e2 = '0;
      end
      if (bd[k] !== e || bl[k] !== (j == 323)) bad++;
      if (bd2[k] !== e2 || bl2[k] !== (j == 323)) bad2++;
    end
    check({tag, "_seq_bad"}, bad, 0);
    check({tag, "_seq_shift_bad"}, bad2, 0);
  endtask

  initial begin
    reset = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = '0; m_ready = 1'b1;
    rnd_rdy = 0; tog = 0;
    pd[0] = 32'h8001_7FFF; pd[1] = 32'h0000_0001; pd[2] = 32'hFFFF_FFFF; pd[3] = 32'h1234_ABCD;
    pd[4] = 32'hDEAD_BEEF; pd[5] = 32'h0BAD_F00D; pd[6] = 32'hCAFE_0042; pd[7] = 32'h5A5A_A5A5;
    for (int k = 0; k < 8; k++) pl[k] = (k == 3) || (k == 7);
    np = 4;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check("rst_m_valid", {31'd0, m_valid}, 32'd0);
    check("rst_m_last", {31'd0, m_last}, 32'd0);
    check("rst_m_data", m_data, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_s_ready", {31'd0, s_ready}, 32'd0);
    reset = 1'b0;

    // 1 + 6: single frame, always ready; shifted instance alongside
    run(FL, 2000);
    check("t1_beat0", bd[0], 32'h0179_0179);
    check("t1_beat16", bd[16], 32'h0179_0179);
    check("t1_beat160", bd[160], 32'h0000_FB02);
    check("t1_beat192", bd[192], 32'h0000_04FE);
    check("t1_pay0", bd[320], 32'h8001_7FFF);
    check("t1_pay3", bd[323], 32'h1234_ABCD);
    check("t1_last323", {31'd0, bl[323]}, 32'd1);
    check("t1_last322", {31'd0, bl[322]}, 32'd0);
    check("t1_contig", bc[FL-1] - bc[0], FL - 1);
    check("t6_beat0", bd2[0], 32'h005E_005E);
    check("t6_beat192", bd2[192], 32'h0000_013F);
    check("t6_pay2", bd2[322], 32'hFFFF_FFFF);
    check_seq("t1");
    @(negedge clk); #1;
    check("t1_idle_busy", {31'd0, busy}, 32'd0);
    check("t1_idle_valid", {31'd0, m_valid}, 32'd0);

    // 2: random backpressure
    rnd_rdy = 1;
    run(FL, 4000);
    check_seq("t2");
    rnd_rdy = 0;

    // 3: payload underflow
    tog = 1;
    run(FL, 2000);
    check_seq("t3");
    check("t3_pay_count", pi, 4);
    check("t3_pre_bubbles", pre_bubbles, 0);
    check("t3_data_bubbles", {31'd0, data_bubbles > 0}, 32'd1);
    tog = 0;

    // 4: reset mid-frame
    run(100, 500);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk); #1;
    check("t4_m_valid", {31'd0, m_valid}, 32'd0);
    check("t4_busy", {31'd0, busy}, 32'd0);
    check("t4_m_data", m_data, 32'd0);
    check("t4_sh_valid", {31'd0, m_valid2}, 32'd0);
    check("t4_sh_busy", {31'd0, busy2}, 32'd0);
    check("t4_sh_ready", {31'd0, s_ready2}, 32'd0);
    reset = 1'b0;
    s_valid = 1'b0;
    run(FL, 2000);
    check("t4_restart_beat0", bd[0], 32'h0179_0179);
    check_seq("t4");

    // 5: back-to-back frames with s_valid held
    np = 8;
    run(2 * FL, 3000);
    check_seq("t5");
    check("t5_last", {31'd0, bl[323]}, 32'd1);
    check("t5_next_first", bc[324] - bc[323], 1);
    check("t5_frame2_beat0", bd[FL], 32'h0179_0179);
    check("t5_frame2_contig", bc[FL] - bc[FL-1], 1);
    check("t5_pay_last", bd[2*FL-1-GAPN], 32'h5A5A_A5A5);

    $display("CHECKS %0d ERRORS %0d", chk, errs);
    $finish;
  end

endmodule
